// File: rtl/alu_pkg.sv
// Shared widths, ALU function codes and owner/grant/slot encodings for the
// arbitrated ALU block.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;
    localparam int CNT_W  = 16;
    localparam int N_REQ  = 2;

    typedef enum logic [SEL_W-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001,
        ALU_NOP  = 4'b1111
    } alu_sel_e;

    // Owner of the result slot and the grant decision share one encoding.
    typedef enum logic {
        OWN_REQ0 = 1'b0,
        OWN_REQ1 = 1'b1
    } owner_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational ALU; unlisted codes and NOP produce 0.
module alu_arbiter_alu
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int SEL_W  = alu_pkg::SEL_W
) (
    input  logic [DATA_W-1:0] i_src1,
    input  logic [DATA_W-1:0] i_src2,
    input  logic [SEL_W-1:0]  i_sel,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zero
);

    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0] w_shamt;
    assign w_shamt = i_src2[SH_W-1:0];

    always_comb begin
        o_result = '0;
        case (i_sel)
            ALU_ADD:  o_result = i_src1 + i_src2;
            ALU_SUB:  o_result = i_src1 - i_src2;
            ALU_SLL:  o_result = i_src1 << w_shamt;
            ALU_SLT:  o_result = {{(DATA_W-1){1'b0}}, ($signed(i_src1) < $signed(i_src2))};
            ALU_SLTU: o_result = {{(DATA_W-1){1'b0}}, (i_src1 < i_src2)};
            ALU_XOR:  o_result = i_src1 ^ i_src2;
            ALU_SRL:  o_result = i_src1 >> w_shamt;
            ALU_SRA:  o_result = $unsigned($signed(i_src1) >>> w_shamt);
            ALU_OR:   o_result = i_src1 | i_src2;
            ALU_AND:  o_result = i_src1 & i_src2;
            default:  o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU through a round-robin grant and a single
// registered result slot that can drain and refill in the same cycle.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int SEL_W  = alu_pkg::SEL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_src1,
    input  logic [DATA_W-1:0] req0_src2,
    input  logic [SEL_W-1:0]  req0_sel,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_src1,
    input  logic [DATA_W-1:0] req1_src2,
    input  logic [SEL_W-1:0]  req1_sel,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic [CNT_W-1:0]  op_cnt0,
    output logic [CNT_W-1:0]  op_cnt1
);

    logic [N_REQ-1:0] w_req_valid;
    logic [N_REQ-1:0] w_rsp_ready;
    logic [N_REQ-1:0] w_rsp_valid;
    logic [N_REQ-1:0] w_rsp_fire;
    logic [CNT_W-1:0] r_op_cnt [N_REQ];

    slot_state_e       r_state, w_state_next;
    owner_e            r_owner, w_owner_next;
    owner_e            r_last_grant, w_grant;
    logic [DATA_W-1:0] r_result, w_result_next;
    logic              r_zero, w_zero_next;
    logic              w_drain, w_can_accept, w_accept;
    logic [DATA_W-1:0] w_src1, w_src2, w_alu_result;
    logic [SEL_W-1:0]  w_sel;
    logic              w_alu_zero;

    assign w_req_valid = {req1_valid, req0_valid};
    assign w_rsp_ready = {rsp1_ready, rsp0_ready};

    always_comb begin
        w_grant = OWN_REQ0;
        if (&w_req_valid) begin
            w_grant = (r_last_grant == OWN_REQ0) ? OWN_REQ1 : OWN_REQ0;
        end else if (w_req_valid[1]) begin
            w_grant = OWN_REQ1;
        end
    end

    // Ready is forced low during reset so nothing is accepted into a slot being cleared.
    assign w_drain      = (r_state == SLOT_FULL) && w_rsp_ready[r_owner];
    assign w_can_accept = !rst && ((r_state == SLOT_EMPTY) || w_drain);
    assign req0_ready   = w_can_accept && (w_grant == OWN_REQ0);
    assign req1_ready   = w_can_accept && (w_grant == OWN_REQ1);
    assign w_accept     = w_can_accept && w_req_valid[w_grant];

    assign w_src1 = (w_grant == OWN_REQ1) ? req1_src1 : req0_src1;
    assign w_src2 = (w_grant == OWN_REQ1) ? req1_src2 : req0_src2;
    assign w_sel  = (w_grant == OWN_REQ1) ? req1_sel  : req0_sel;

    alu_arbiter_alu #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) u_alu (
        .i_src1   (w_src1),
        .i_src2   (w_src2),
        .i_sel    (w_sel),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero)
    );

    always_comb begin
        w_state_next  = r_state;
        w_owner_next  = r_owner;
        w_result_next = r_result;
        w_zero_next   = r_zero;
        if (w_accept) begin
            w_state_next  = SLOT_FULL;
            w_owner_next  = w_grant;
            w_result_next = w_alu_result;
            w_zero_next   = w_alu_zero;
        end else if (w_drain) begin
            w_state_next  = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= SLOT_EMPTY;
            r_owner      <= OWN_REQ0;
            r_result     <= '0;
            r_zero       <= 1'b0;
            r_last_grant <= OWN_REQ1;
        end else begin
            r_state  <= w_state_next;
            r_owner  <= w_owner_next;
            r_result <= w_result_next;
            r_zero   <= w_zero_next;
            if (w_accept) begin
                r_last_grant <= w_grant;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rsp
            assign w_rsp_valid[gi] = (r_state == SLOT_FULL) && (int'(r_owner) == gi);
            assign w_rsp_fire[gi]  = w_rsp_valid[gi] && w_rsp_ready[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_op_cnt[gi] <= '0;
                end else if (w_rsp_fire[gi] && (r_op_cnt[gi] != {CNT_W{1'b1}})) begin
                    r_op_cnt[gi] <= r_op_cnt[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign rsp0_valid = w_rsp_valid[0];
    assign rsp1_valid = w_rsp_valid[1];
    assign rsp_result = r_result;
    assign rsp_zero   = r_zero;
    assign op_cnt0    = r_op_cnt[0];
    assign op_cnt1    = r_op_cnt[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared each cycle against a transaction-level model.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_src1 = '0, req0_src2 = '0, req1_src1 = '0, req1_src2 = '0;
    logic [3:0]  req0_sel = '0, req1_sel = '0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic [15:0] op_cnt0, op_cnt1;

    alu_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_src1  (req0_src1),
        .req0_src2  (req0_src2),
        .req0_sel   (req0_sel),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_src1  (req1_src1),
        .req1_src2  (req1_src2),
        .req1_sel   (req1_sel),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .op_cnt0    (op_cnt0),
        .op_cnt1    (op_cnt1)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: one slot, a round-robin pointer, two counters
    bit          m_full  = 1'b0;
    int          m_owner = 0;
    int          m_last  = 1;
    logic [31:0] m_result = '0;
    bit          m_zero  = 1'b0;
    int          m_cnt [2] = '{0, 0};

    function automatic logic [31:0] ref_alu(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (sel)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a << b[4:0];
            4'd3:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:    r = (a < b) ? 32'd1 : 32'd0;
            4'd5:    r = a ^ b;
            4'd6:    r = a >> b[4:0];
            4'd7:    r = $signed(a) >>> b[4:0];
            4'd8:    r = a | b;
            4'd9:    r = a & b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic int m_grant();
        if (req0_valid && req1_valid) return 1 - m_last;
        return req1_valid ? 1 : 0;
    endfunction

    function automatic bit m_owner_ready();
        return (m_owner == 0) ? rsp0_ready : rsp1_ready;
    endfunction

    function automatic bit m_can();
        return !rst && (!m_full || m_owner_ready());
    endfunction

    task automatic model_step();
        int g;
        bit acc;
        bit drain;
        if (rst) begin
            m_full = 1'b0; m_result = '0; m_zero = 1'b0; m_last = 1;
            m_cnt[0] = 0; m_cnt[1] = 0;
        end else begin
            g     = m_grant();
            drain = m_full && m_owner_ready();
            acc   = m_can() && ((g == 0) ? req0_valid : req1_valid);
            if (drain && m_cnt[m_owner] < 65535) m_cnt[m_owner]++;
            if (acc) begin
                m_full   = 1'b1;
                m_owner  = g;
                m_result = (g == 0) ? ref_alu(req0_sel, req0_src1, req0_src2)
                                    : ref_alu(req1_sel, req1_src1, req1_src2);
                m_zero   = (m_result == 32'd0);
                m_last   = g;
            end else if (drain) begin
                m_full = 1'b0;
            end
        end
    endtask

    // Compare process: outputs checked mid-cycle, model advanced on each rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("m_req0_ready", 32'(req0_ready), 32'(m_can() && m_grant() == 0));
                chk("m_req1_ready", 32'(req1_ready), 32'(m_can() && m_grant() == 1));
                chk("m_rsp0_valid", 32'(rsp0_valid), 32'(m_full && m_owner == 0));
                chk("m_rsp1_valid", 32'(rsp1_valid), 32'(m_full && m_owner == 1));
                chk("m_op_cnt0", 32'(op_cnt0), 32'(m_cnt[0]));
                chk("m_op_cnt1", 32'(op_cnt1), 32'(m_cnt[1]));
                if (m_full) begin
                    chk("m_rsp_result", rsp_result, m_result);
                    chk("m_rsp_zero", 32'(rsp_zero), 32'(m_zero));
                end
            end
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- stimulus
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    function automatic logic [31:0] rnd_operand();
        if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 4));
        return $urandom;
    endfunction

    initial begin
        bit reached;
        int k;

        // Reset state
        step(); step();
        chk_en = 1'b1;
        req0_valid = 1'b1;
        @(negedge clk);
        chk("rst_req0_ready", 32'(req0_ready), 0);
        chk("rst_rsp0_valid", 32'(rsp0_valid), 0);
        chk("rst_rsp1_valid", 32'(rsp1_valid), 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_zero", 32'(rsp_zero), 0);
        chk("rst_cnt0", 32'(op_cnt0), 0);

        // Single add 5+7 from requester 0
        step();
        rst = 1'b0;
        req0_valid = 1'b1; req0_sel = ALU_ADD; req0_src1 = 32'd5; req0_src2 = 32'd7;
        @(negedge clk);
        chk("add_req0_ready", 32'(req0_ready), 1);
        step();
        req0_valid = 1'b0; rsp0_ready = 1'b1;
        @(negedge clk);
        chk("add_rsp0_valid", 32'(rsp0_valid), 1);
        chk("add_result", rsp_result, 32'd12);
        chk("add_zero", 32'(rsp_zero), 0);
        step();
        rsp0_ready = 1'b0;
        @(negedge clk);
        chk("add_cnt0", 32'(op_cnt0), 1);

        // Continuous contention: grants alternate starting at requester 0
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0_valid = 1'b1; req0_sel = ALU_SUB; req0_src1 = 32'd3;    req0_src2 = 32'd3;
        req1_valid = 1'b1; req1_sel = ALU_OR;  req1_src1 = 32'hF0;   req1_src2 = 32'h0F;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr_req0_ready", 32'(req0_ready), 32'(i % 2 == 0));
            chk("rr_req1_ready", 32'(req1_ready), 32'(i % 2 == 1));
            if (i > 0) begin
                chk("rr_result", rsp_result, ((i - 1) % 2 == 0) ? 32'd0 : 32'hFF);
                chk("rr_zero", 32'(rsp_zero), 32'((i - 1) % 2 == 0));
            end
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        // Held result: req1 sltu 1,2 with consumer stalled
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_sel = ALU_SLTU; req1_src1 = 32'd1; req1_src2 = 32'd2;
        @(negedge clk);
        chk("sltu_req1_ready", 32'(req1_ready), 1);
        step();
        req0_valid = 1'b1; req0_sel = ALU_ADD; req0_src1 = 32'd1; req0_src2 = 32'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_rsp1_valid", 32'(rsp1_valid), 1);
            chk("hold_result", rsp_result, 32'd1);
            chk("hold_req0_ready", 32'(req0_ready), 0);
            chk("hold_req1_ready", 32'(req1_ready), 0);
            step();
        end

        // Drain of one owner with same-cycle refill by the other
        rsp1_ready = 1'b1; req1_valid = 1'b0;
        @(negedge clk);
        chk("refill_req0_ready", 32'(req0_ready), 1);
        step();
        rsp1_ready = 1'b0; rsp0_ready = 1'b1; req0_valid = 1'b0;
        req1_valid = 1'b1; req1_sel = ALU_XOR; req1_src1 = 32'd6; req1_src2 = 32'd3;
        @(negedge clk);
        chk("refill_rsp0_valid", 32'(rsp0_valid), 1);
        chk("refill_result0", rsp_result, 32'd2);
        chk("refill_req1_ready", 32'(req1_ready), 1);
        step();
        idle();
        @(negedge clk);
        chk("swap_rsp1_valid", 32'(rsp1_valid), 1);
        chk("swap_rsp0_valid", 32'(rsp0_valid), 0);
        chk("swap_result", rsp_result, 32'd5);

        // Reset while a result is held for requester 0
        step();
        rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_sel = ALU_ADD; req0_src1 = 32'd9; req0_src2 = 32'd0;
        step();
        rsp1_ready = 1'b0; req0_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_result", rsp_result, 32'd9);
        step();
        rst = 1'b1; rsp0_ready = 1'b1; req0_valid = 1'b1;
        @(negedge clk);
        chk("mid_rst_req0_ready", 32'(req0_ready), 0);
        step();
        rst = 1'b0; rsp0_ready = 1'b0; req1_valid = 1'b1;
        @(negedge clk);
        chk("post_rst_rsp0_valid", 32'(rsp0_valid), 0);
        chk("post_rst_result", rsp_result, 0);
        chk("post_rst_cnt0", 32'(op_cnt0), 0);
        chk("post_rst_grant0", 32'(req0_ready), 1);
        chk("post_rst_grant1", 32'(req1_ready), 0);

        // Randomized traffic, model-checked every cycle
        for (int i = 0; i < 3000; i++) begin
            step();
            rst        = ($urandom_range(0, 99) == 0);
            req0_valid = $urandom_range(0, 1) == 1;
            req1_valid = $urandom_range(0, 1) == 1;
            rsp0_ready = $urandom_range(0, 9) < 7;
            rsp1_ready = $urandom_range(0, 9) < 7;
            req0_sel   = 4'($urandom_range(0, 15));
            req1_sel   = 4'($urandom_range(0, 15));
            req0_src1  = rnd_operand(); req0_src2 = rnd_operand();
            req1_src1  = rnd_operand(); req1_src2 = rnd_operand();
        end

        // Counter saturation through back-to-back completions
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0_valid = 1'b1; req0_sel = ALU_ADD; req0_src1 = 32'd1; req0_src2 = 32'd2;
        rsp0_ready = 1'b1;
        reached = 1'b0;
        k = 0;
        while (!reached && k < 70000) begin
            @(negedge clk);
            reached = (op_cnt0 == 16'hFFFF);
            k++;
            if (!reached) step();
        end
        chk("sat_reached", 32'(reached), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("sat_cnt0", 32'(op_cnt0), 32'hFFFF);
            chk("sat_rsp0_valid", 32'(rsp0_valid), 1);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
